// File: rtl/add_sub_cs_pipe.sv
// Three-stage handshaked add/sub on the solver's scaled fixed-point word {scale, signed mantissa}.
// S1 aligns operands, S2 runs a BLOCK_W carry-select adder, S3 renormalises or saturates.
module add_sub_cs_pipe #(
  parameter int MANT_W  = 13,
  parameter int SCALE_W = 3,
  parameter int BLOCK_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MANT_W+SCALE_W-1:0]  in1,
  input  logic [MANT_W+SCALE_W-1:0]  in2,
  input  logic                       sub,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MANT_W+SCALE_W-1:0]  out,
  output logic                       cout,
  output logic                       invalid
);

  localparam int W      = MANT_W + SCALE_W;
  localparam int MAX_SC = (1 << SCALE_W) - 1;
  localparam int RAW_W  = MANT_W + (1 << SCALE_W);
  localparam int IW     = ((RAW_W + BLOCK_W - 1) / BLOCK_W) * BLOCK_W;
  localparam int NB     = IW / BLOCK_W;

  function automatic logic fits_mant(input logic [IW-1:0] v);
    return (&v[IW-1:MANT_W-1]) || !(|v[IW-1:MANT_W-1]);
  endfunction

  // Stage occupancy and advance conditions; a stage may load when its slot frees this cycle.
  logic s1_valid, s2_valid, go2, go3;

  assign go3      = !out_valid || out_ready;
  assign go2      = !s2_valid || go3;
  assign in_ready = !s1_valid || go2;

  // ---------------- S1: decode / align ----------------
  logic [SCALE_W-1:0]   sc1, sc2, sr_in, diff;
  logic [IW-1:0]        ext1, ext2, al1, al2;
  logic [IW-1:0]        s1_a, s1_b;
  logic                 s1_c;
  logic [SCALE_W-1:0]   s1_sr;

  always_comb begin
    sc1  = in1[W-1:MANT_W];
    sc2  = in2[W-1:MANT_W];
    ext1 = {{(IW-MANT_W){in1[MANT_W-1]}}, in1[MANT_W-1:0]};
    ext2 = {{(IW-MANT_W){in2[MANT_W-1]}}, in2[MANT_W-1:0]};
    if (sc1 >= sc2) begin
      sr_in = sc1;
      diff  = sc1 - sc2;
      al1   = ext1;
      al2   = ext2 << diff;
    end else begin
      sr_in = sc2;
      diff  = sc2 - sc1;
      al1   = ext1 << diff;
      al2   = ext2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= 1'b0;
      s1_sr    <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_a  <= al1;
        s1_b  <= sub ? ~al2 : al2;
        s1_c  <= sub ? ~cin : cin;
        s1_sr <= sr_in;
      end
    end
  end

  // ---------------- S2: carry-select add ----------------
  logic [NB-1:0][BLOCK_W:0] blk_s0, blk_s1;
  logic [IW-1:0]            sum_cs;
  logic                     sel_c;
  logic [IW-1:0]            s2_sum;
  logic                     s2_cout;
  logic [SCALE_W-1:0]       s2_sr;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    assign blk_s0[g] = {1'b0, s1_a[g*BLOCK_W +: BLOCK_W]} + {1'b0, s1_b[g*BLOCK_W +: BLOCK_W]};
    assign blk_s1[g] = {1'b0, s1_a[g*BLOCK_W +: BLOCK_W]} + {1'b0, s1_b[g*BLOCK_W +: BLOCK_W]}
                       + (BLOCK_W+1)'(1);
  end

  // NOTE: every always_comb output gets a value on entry so no latch can be inferred.
  always_comb begin
    sum_cs = '0;
    sel_c  = s1_c;
    for (int i = 0; i < NB; i++) begin
      sum_cs[i*BLOCK_W +: BLOCK_W] = sel_c ? blk_s1[i][BLOCK_W-1:0] : blk_s0[i][BLOCK_W-1:0];
      sel_c = sel_c ? blk_s1[i][BLOCK_W] : blk_s0[i][BLOCK_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_sr    <= '0;
    end else begin
      if (go2) s2_valid <= s1_valid;
      if (s1_valid && go2) begin
        s2_sum  <= sum_cs;
        s2_cout <= sel_c;
        s2_sr   <= s1_sr;
      end
    end
  end

  // ---------------- S3: renormalise / saturate ----------------
  logic signed [IW-1:0] rn_s;
  logic [SCALE_W-1:0]   rn_sc;
  logic                 rn_lost, rn_inv;
  logic [W-1:0]         rn_out;

  always_comb begin
    rn_s    = s2_sum;
    rn_sc   = s2_sr;
    rn_lost = 1'b0;
    for (int i = 0; i < MAX_SC; i++) begin
      if (rn_sc != '0 && !fits_mant(rn_s)) begin
        rn_lost = rn_lost | rn_s[0];
        rn_s    = rn_s >>> 1;
        rn_sc   = rn_sc - SCALE_W'(1);
      end
    end
    if (fits_mant(rn_s)) begin
      rn_out = {rn_sc, rn_s[MANT_W-1:0]};
      rn_inv = rn_lost;
    end else begin
      rn_out = rn_s[IW-1] ? {{SCALE_W{1'b0}}, 1'b1, {(MANT_W-1){1'b0}}}
                          : {{SCALE_W{1'b0}}, 1'b0, {(MANT_W-1){1'b1}}};
      rn_inv = 1'b1;
    end
  end

  // NOTE: data registers are reset too; the pipeline is shallow and out/cout/invalid must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      if (go3) out_valid <= s2_valid;
      if (s2_valid && go3) begin
        out     <= rn_out;
        cout    <= s2_cout;
        invalid <= rn_inv;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_cs_pipe.sv
// Self-checking bench for add_sub_cs_pipe: directed vectors, backpressure, random stream
// against an integer-arithmetic reference model, and mid-stream reset.
module tb_add_sub_cs_pipe;

  localparam int MW   = 13;
  localparam int SW   = 3;
  localparam int BW   = 4;
  localparam int W    = MW + SW;
  localparam int RAW  = MW + (1 << SW);
  localparam int IW   = ((RAW + BW - 1) / BW) * BW;
  localparam longint MAXP = (longint'(1) << (MW - 1)) - 1;
  localparam longint MINN = -(longint'(1) << (MW - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         cout;
  logic         invalid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic         cout;
    logic         invalid;
  } res_t;

  res_t exp_q[$];

  add_sub_cs_pipe #(.MANT_W(MW), .SCALE_W(SW), .BLOCK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Reference: exact value arithmetic at the common scale, then halve until it fits.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sb, input logic ci);
    res_t   r;
    longint m1, m2, a, b, total, mask, au, bu, cu;
    int     s1, s2, sr;
    logic   lost;
    m1 = longint'($signed(x[MW-1:0]));
    m2 = longint'($signed(y[MW-1:0]));
    s1 = int'(x[W-1:MW]);
    s2 = int'(y[W-1:MW]);
    sr = (s1 > s2) ? s1 : s2;
    a  = m1 * (longint'(1) << (sr - s1));
    b  = m2 * (longint'(1) << (sr - s2));
    total = sb ? (a - b - longint'(ci)) : (a + b + longint'(ci));
    mask = (longint'(1) << IW) - 1;
    au = a & mask;
    bu = (sb ? ~b : b) & mask;
    cu = sb ? longint'(!ci) : longint'(ci);
    r.cout = (((au + bu + cu) >> IW) & 1) != 0;
    lost = 1'b0;
    while (sr > 0 && (total > MAXP || total < MINN)) begin
      if ((total & 1) != 0) lost = 1'b1;
      total = total >>> 1;
      sr = sr - 1;
    end
    if (total <= MAXP && total >= MINN) begin
      r.out     = {sr[SW-1:0], total[MW-1:0]};
      r.invalid = lost;
    end else begin
      r.out     = (total < 0) ? {{SW{1'b0}}, 1'b1, {(MW-1){1'b0}}}
                              : {{SW{1'b0}}, 1'b0, {(MW-1){1'b1}}};
      r.invalid = 1'b1;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b want 0", cout); end
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got %0b want 0", invalid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] t_in1 [9] = '{16'h0002, 16'h0002, 16'h2007, 16'h848D, 16'h2FFE,
                                16'h0FFF, 16'h1000, 16'h2007, 16'h0005};
    logic [W-1:0] t_in2 [9] = '{16'h0003, 16'h0003, 16'h4003, 16'hE14A, 16'h2002,
                                16'h0001, 16'h0001, 16'h4003, 16'h0002};
    logic         t_sub [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic         t_cin [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    logic [W-1:0] t_out [9] = '{16'h0005, 16'h0006, 16'h4011, 16'hA96C, 16'h0800,
                                16'h0FFF, 16'h1000, 16'h400B, 16'h0002};
    logic         t_inv [9] = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    res_t e;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in1 = t_in1[i]; in2 = t_in2[i]; sub = t_sub[i]; cin = t_cin[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      e = model(t_in1[i], t_in2[i], t_sub[i], t_cin[i]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %0b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %0b want 0", i, out_valid); end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency_valid got %0b want 1", i, out_valid); end
      checks++; if (out !== t_out[i]) begin errors++; $display("FAIL dir%0d_out got %h want %h", i, out, t_out[i]); end
      checks++; if (invalid !== t_inv[i]) begin errors++; $display("FAIL dir%0d_invalid got %0b want %0b", i, invalid, t_inv[i]); end
      checks++; if (cout !== e.cout) begin errors++; $display("FAIL dir%0d_cout got %0b want %0b", i, cout, e.cout); end
    end
  endtask

  task automatic test_backpressure();
    int   accepted = 0;
    res_t held, e;
    @(negedge clk);
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in1 = W'($urandom); in2 = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      #1;
      if (b == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_fourth_ready got %0b want 0", in_ready); end
      end
      if (in_ready) begin
        accepted++;
        exp_q.push_back(model(in1, in2, sub, cin));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (accepted != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", accepted); end
    #1;
    held = {out, cout, invalid};
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0b want 1", out_valid); end
    checks++; if ({out, cout, invalid} !== held) begin errors++; $display("FAIL bp_hold_stable got %h want %h", {out, cout, invalid}, held); end
    @(negedge clk);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain%0d_valid got %0b want 1", j, out_valid); end
      checks++; if ({out, cout, invalid} !== e) begin errors++; $display("FAIL bp_drain%0d_result got %h want %h", j, {out, cout, invalid}, e); end
      @(negedge clk);
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    localparam int N = 2000;
    res_t held, e;
    logic hold_pending = 1'b0;
    bit   done = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < N + 100 && !done; cyc++) begin
      @(negedge clk);
      if (cyc < N) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in1       = W'($urandom);
        in2       = W'($urandom);
        sub       = 1'($urandom);
        cin       = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (hold_pending) begin
        checks++;
        if (out_valid !== 1'b1 || {out, cout, invalid} !== held) begin
          errors++;
          $display("FAIL rnd_hold cyc %0d got v=%0b %h want v=1 %h", cyc, out_valid, {out, cout, invalid}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected cyc %0d got %h want no result", cyc, {out, cout, invalid});
        end else begin
          e = exp_q.pop_front();
          if ({out, cout, invalid} !== e) begin
            errors++;
            $display("FAIL rnd_result cyc %0d got %h want %h", cyc, {out, cout, invalid}, e);
          end
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out, cout, invalid};
      if (in_valid && in_ready) exp_q.push_back(model(in1, in2, sub, cin));
      if (cyc >= N && exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in1 = W'($urandom); in2 = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b want 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b want 0", out_valid); end
    checks++; if (out !== '0) begin errors++; $display("FAIL rst_async_out got %h want 0000", out); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale%0d_valid got %0b want 0", j, out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready got %0b want 1", in_ready); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
